// File: rtl/pwd_pkg.sv
// Shared definitions for the password oracle: digit encoding, charset helpers, FSM states.
package pwd_pkg;

  localparam int DIGIT_W         = 6;
  localparam int CHARSET_SIZE    = 36;
  localparam int ASCII_DIG_OFS   = 48;
  localparam int ASCII_ALPHA_OFS = 87;

  typedef enum logic [2:0] {
    ST_EMPTY,
    ST_LOADING,
    ST_ARMED,
    ST_CHECK,
    ST_RESPOND,
    ST_LOCKED
  } pwd_state_e;

  // Only meaningful for d < CHARSET_SIZE; callers gate larger digits.
  function automatic logic [7:0] digit_to_ascii(input logic [DIGIT_W-1:0] d);
    if (d < 6'd10) return 8'(d) + 8'(ASCII_DIG_OFS);
    else           return 8'(d) + 8'(ASCII_ALPHA_OFS);
  endfunction

  function automatic logic is_charset(input logic [7:0] b);
    return ((b >= 8'd48) && (b <= 8'd57)) || ((b >= 8'd97) && (b <= 8'd122));
  endfunction

endpackage

// File: rtl/pwd_char_cmp.sv
// Compares one candidate digit against one stored password byte.
module pwd_char_cmp
  import pwd_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  input  logic [7:0]         i_char,
  output logic               o_eq
);

  // Digits beyond the charset must never match, whatever the stored byte is.
  assign o_eq = (i_digit < 6'(CHARSET_SIZE)) && (digit_to_ascii(i_digit) == i_char);

endmodule

// File: rtl/pwd_oracle.sv
// Password oracle: byte-serial password load, then candidate queries answered match/no-match.
// Optional consecutive-failure lockout enabled by defining PWD_ORACLE_LOCKOUT_EN.
module pwd_oracle
  import pwd_pkg::*;
#(
  parameter int NUM_CHARS = 4,
  parameter int MAX_TRIES = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_valid,
  input  logic [7:0]                   load_data,
  output logic                         load_ready,
  input  logic                         cand_valid,
  input  logic [DIGIT_W*NUM_CHARS-1:0] cand_digits,
  output logic                         cand_ready,
  output logic                         resp_valid,
  output logic                         resp_match,
  input  logic                         resp_ready,
  output logic                         armed,
  output logic                         locked,
  output logic [15:0]                  attempts
);

  localparam int IDX_W = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;

  if (NUM_CHARS < 1 || MAX_TRIES < 1) begin : g_param_chk
    $error("pwd_oracle: NUM_CHARS and MAX_TRIES must be >= 1");
  end

  pwd_state_e                   r_state;
  logic [IDX_W-1:0]             r_idx;
  logic [NUM_CHARS-1:0][7:0]    r_pwd;
  logic [DIGIT_W*NUM_CHARS-1:0] r_cand;
  logic [15:0]                  r_attempts;
  logic                         r_load_ready;
  logic                         r_cand_ready;
  logic                         r_resp_valid;
  logic                         r_resp_match;
  logic                         r_armed;
  logic [NUM_CHARS-1:0]         w_eq;

  for (genvar g = 0; g < NUM_CHARS; g++) begin : g_cmp
    pwd_char_cmp u_cmp (
      .i_digit (r_cand[DIGIT_W*g +: DIGIT_W]),
      .i_char  (r_pwd[g]),
      .o_eq    (w_eq[g])
    );
  end

`ifdef PWD_ORACLE_LOCKOUT_EN
  localparam int FAIL_W = $clog2(MAX_TRIES + 1);
  logic [FAIL_W-1:0] r_fail_cnt;
  logic              r_locked;
  assign locked = r_locked;
`else
  assign locked = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_EMPTY;
      r_idx        <= '0;
      r_pwd        <= '0;
      r_cand       <= '0;
      r_attempts   <= '0;
      r_load_ready <= 1'b1;
      r_cand_ready <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_match <= 1'b0;
      r_armed      <= 1'b0;
`ifdef PWD_ORACLE_LOCKOUT_EN
      r_fail_cnt   <= '0;
      r_locked     <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_EMPTY, ST_LOADING: begin
          // Out-of-charset bytes are swallowed without advancing the index.
          if (load_valid && is_charset(load_data)) begin
            r_pwd[r_idx] <= load_data;
            if (r_idx == IDX_W'(NUM_CHARS - 1)) begin
              r_state      <= ST_ARMED;
              r_load_ready <= 1'b0;
              r_cand_ready <= 1'b1;
              r_armed      <= 1'b1;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= ST_LOADING;
            end
          end
        end
        ST_ARMED: begin
          if (cand_valid) begin
            r_cand       <= cand_digits;
            r_cand_ready <= 1'b0;
            r_state      <= ST_CHECK;
            if (r_attempts != 16'hFFFF) r_attempts <= r_attempts + 16'd1;
          end
        end
        ST_CHECK: begin
          r_resp_match <= &w_eq;
          r_resp_valid <= 1'b1;
          r_state      <= ST_RESPOND;
        end
        ST_RESPOND: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_match <= 1'b0;
            r_state      <= ST_ARMED;
            r_cand_ready <= 1'b1;
`ifdef PWD_ORACLE_LOCKOUT_EN
            if (r_resp_match) begin
              r_fail_cnt <= '0;
            end else if (r_fail_cnt == FAIL_W'(MAX_TRIES - 1)) begin
              r_fail_cnt   <= r_fail_cnt + 1'b1;
              r_state      <= ST_LOCKED;
              r_cand_ready <= 1'b0;
              r_locked     <= 1'b1;
            end else begin
              r_fail_cnt <= r_fail_cnt + 1'b1;
            end
`endif
          end
        end
        ST_LOCKED: ;
        default: begin
          r_state      <= ST_EMPTY;
          r_idx        <= '0;
          r_load_ready <= 1'b1;
          r_cand_ready <= 1'b0;
          r_resp_valid <= 1'b0;
          r_resp_match <= 1'b0;
          r_armed      <= 1'b0;
        end
      endcase
    end
  end

  assign load_ready = r_load_ready;
  assign cand_ready = r_cand_ready;
  assign resp_valid = r_resp_valid;
  assign resp_match = r_resp_match;
  assign armed      = r_armed;
  assign attempts   = r_attempts;

endmodule
